// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
package regfile_wb_pkg;

  // Result / register width. The top-level DATA_WIDTH must match this value.
  parameter int DATA_WIDTH = 32;

  localparam int         REG_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] RF_WE_ON   = 5'b00001;
  localparam logic [4:0] RF_WE_OFF  = 5'b00000;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending write-back entries.
// Exposes the raw storage and read pointer so the top can scan pending writes
// in age order for forwarding. DEPTH must be a power of two (pointers wrap
// naturally); count distinguishes full from empty.
module wb_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   push,
  input  regfile_wb_pkg::wb_entry_t              push_entry,
  input  logic                                   pop,
  output regfile_wb_pkg::wb_entry_t              head,
  output logic [CNT_W-1:0]                       count,
  output logic [PTR_W-1:0]                       rd_ptr,
  output regfile_wb_pkg::wb_entry_t [DEPTH-1:0]  entries
);
  import regfile_wb_pkg::*;

  wb_entry_t [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  // Entry storage: written at the tail on push, no reset needed (count gates use).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head    = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign rd_ptr  = rd_ptr_r;
  assign entries = mem_r;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue: buffers ALU and load results and issues at most one
// register-file write per cycle. Load results have priority over ALU results;
// writes to r0 are accepted but discarded.
// Optional feature macro: WB_FORWARD_EN (forwarding lookup over pending writes).
module regfile_wb_queue #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [4:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [4:0]            rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [CNT_W-1:0]      count,
  output logic                  idle,
  input  logic [4:0]            fwd_raddr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);
  import regfile_wb_pkg::*;

  logic                  not_full_s;
  logic                  mem_fire_s;
  logic                  alu_fire_s;
  logic                  push_s;
  logic                  pop_s;
  wb_entry_t             push_entry_s;
  wb_entry_t             head_s;
  logic [CNT_W-1:0]      count_s;
  logic [PTR_W-1:0]      rd_ptr_s;
  wb_entry_t [DEPTH-1:0] entries_s;

  logic [4:0]            rf_we_r;
  logic [4:0]            rf_waddr_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;

  // Readies depend only on current occupancy; a same-cycle pop frees nothing.
  assign not_full_s = (count_s < CNT_W'(DEPTH));
  assign mem_ready  = not_full_s;
  assign alu_ready  = not_full_s && !mem_valid;
  assign mem_fire_s = mem_valid && mem_ready;
  assign alu_fire_s = alu_valid && alu_ready;
  assign pop_s      = (count_s != {CNT_W{1'b0}});

  // Select the winning producer and drop r0 destinations.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = '0;
    if (mem_fire_s) begin
      push_s            = (mem_addr != REG_ZERO);
      push_entry_s.addr = mem_addr;
      push_entry_s.data = mem_data;
    end else if (alu_fire_s) begin
      push_s            = (alu_addr != REG_ZERO);
      push_entry_s.addr = alu_addr;
      push_entry_s.data = alu_data;
    end else begin
      push_s       = 1'b0;
      push_entry_s = '0;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .count      (count_s),
    .rd_ptr     (rd_ptr_s),
    .entries    (entries_s)
  );

  // Register-file write port: pop the head every edge the queue is non-empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= RF_WE_OFF;
      rf_waddr_r <= REG_ZERO;
      rf_wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      rf_we_r    <= RF_WE_ON;
      rf_waddr_r <= head_s.addr;
      rf_wdata_r <= head_s.data;
    end else begin
      rf_we_r    <= RF_WE_OFF;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign count    = count_s;
  assign idle     = (count_s == {CNT_W{1'b0}}) && (rf_we_r == RF_WE_OFF);

`ifdef WB_FORWARD_EN
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] fwd_data_s;
  logic [PTR_W-1:0]      fwd_idx_s;
  logic                  fwd_match_s;

  // Scan oldest to youngest (rf_* register, then FIFO head to tail); last match wins.
  always_comb begin
    fwd_hit_s   = 1'b0;
    fwd_data_s  = {DATA_WIDTH{1'b0}};
    fwd_idx_s   = {PTR_W{1'b0}};
    fwd_match_s = (rf_we_r != RF_WE_OFF) && (rf_waddr_r == fwd_raddr);
    fwd_hit_s   = fwd_match_s;
    fwd_data_s  = fwd_match_s ? rf_wdata_r : {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s   = rd_ptr_s + PTR_W'(i);
      fwd_match_s = (CNT_W'(i) < count_s) && (entries_s[fwd_idx_s].addr == fwd_raddr);
      fwd_hit_s   = fwd_match_s ? 1'b1 : fwd_hit_s;
      fwd_data_s  = fwd_match_s ? entries_s[fwd_idx_s].data : fwd_data_s;
    end
    if (fwd_raddr == REG_ZERO) begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      fwd_hit_s  = fwd_hit_s;
      fwd_data_s = fwd_data_s;
    end
  end

  assign fwd_hit  = fwd_hit_s;
  assign fwd_data = fwd_data_s;
`else
  logic unused_fwd_s;

  // Lookup disabled: the address and the FIFO storage view are not consumed.
  assign unused_fwd_s = ^{fwd_raddr, rd_ptr_s, entries_s};
  assign fwd_hit      = 1'b0;
  assign fwd_data     = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue (DATA_WIDTH=32, DEPTH=4).
module tb_regfile_wb_queue;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = 5'd0;
  logic [31:0] mem_data = 32'd0;
  logic [4:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  count;
  logic        idle;
  logic [4:0]  fwd_raddr = 5'd0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .count(count), .idle(idle),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (rf_we !== 5'd0) begin n_err++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_rf_waddr got=%0h exp=0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem_ready, alu_ready} !== 2'b11) begin n_err++; $display("FAIL reset_readies got=%b exp=11", {mem_ready, alu_ready}); end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_alu_ready got=%0b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1 got=%0d exp=1", count); end
    n_cmp++; if (rf_we !== 5'd0) begin n_err++; $display("FAIL single_we_early got=%0h exp=0", rf_we); end
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {5'b00001, 5'd5, 32'hDEADBEEF})
      begin n_err++; $display("FAIL single_write got=%0h/%0d/%0h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0 got=%0d exp=0", count); end
    n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%0b exp=0", idle); end
    tick();
    n_cmp++; if (rf_we !== 5'd0) begin n_err++; $display("FAIL single_we_off got=%0h exp=0", rf_we); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle got=%0b exp=1", idle); end
    n_cmp++; if ({rf_waddr, rf_wdata} !== {5'd5, 32'hDEADBEEF})
      begin n_err++; $display("FAIL single_hold got=%0d/%0h exp=5/deadbeef", rf_waddr, rf_wdata); end
  endtask

  task automatic test_priority();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
    #1;
    n_cmp++; if ({mem_ready, alu_ready} !== 2'b10) begin n_err++; $display("FAIL prio_readies got=%b exp=10", {mem_ready, alu_ready}); end
    tick();
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_ready2 got=%0b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {5'b00001, 5'd2, 32'h22})
      begin n_err++; $display("FAIL prio_first got=%0h/%0d/%0h exp=1/2/22", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL prio_count got=%0d exp=1", count); end
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {5'b00001, 5'd1, 32'h11})
      begin n_err++; $display("FAIL prio_second got=%0h/%0d/%0h exp=1/1/11", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL prio_idle got=%0b exp=1", idle); end
  endtask

  // Both producers held valid: load wins every cycle, ALU gets in once the load stream stops.
  task automatic test_back_to_back();
    logic [4:0]  aq[$];
    logic [31:0] dq[$];
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        popped;
    bit          m_rdy;
    bit          a_rdy;
    int          cnt_m = 0;
    for (int i = 0; i < 12; i++) begin
      mem_valid = (i < 8);
      mem_addr  = 5'(8 + i);
      mem_data  = 32'h100 + 32'(i);
      alu_valid = (i < 9);
      alu_addr  = 5'd3;
      alu_data  = 32'h33;
      #1;
      m_rdy = (cnt_m < 4);
      a_rdy = (cnt_m < 4) && !mem_valid;
      n_cmp++; if ({mem_ready, alu_ready} !== {m_rdy, a_rdy})
        begin n_err++; $display("FAIL b2b_readies[%0d] got=%b exp=%b", i, {mem_ready, alu_ready}, {m_rdy, a_rdy}); end
      popped = (cnt_m > 0);
      ea = 5'd0; ed = 32'd0;
      if (popped) begin ea = aq.pop_front(); ed = dq.pop_front(); end
      if (mem_valid && m_rdy) begin
        if (mem_addr != 5'd0) begin aq.push_back(mem_addr); dq.push_back(mem_data); end
      end else if (alu_valid && a_rdy) begin
        if (alu_addr != 5'd0) begin aq.push_back(alu_addr); dq.push_back(alu_data); end
      end
      cnt_m = aq.size();
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      n_cmp++; if (rf_we !== (popped ? 5'b00001 : 5'b00000))
        begin n_err++; $display("FAIL b2b_we[%0d] got=%0h exp=%0h", i, rf_we, popped ? 5'b00001 : 5'b00000); end
      if (popped) begin
        n_cmp++; if ({rf_waddr, rf_wdata} !== {ea, ed})
          begin n_err++; $display("FAIL b2b_data[%0d] got=%0d/%0h exp=%0d/%0h", i, rf_waddr, rf_wdata, ea, ed); end
      end
      n_cmp++; if (count !== 3'(cnt_m)) begin n_err++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, count, cnt_m); end
    end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL x0_count got=%0d exp=0", count); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (rf_we !== 5'd0) begin n_err++; $display("FAIL x0_we[%0d] got=%0h exp=0", i, rf_we); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(20 + i); mem_data = 32'hC0DE0000 + 32'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    mem_valid = 1'b0;
    rst = 1'b0;
    n_cmp++; if ({rf_we, count} !== {5'd0, 3'd0}) begin n_err++; $display("FAIL rstmid_state got=%0h/%0d exp=0/0", rf_we, count); end
    n_cmp++; if ({rf_waddr, rf_wdata} !== {5'd0, 32'd0}) begin n_err++; $display("FAIL rstmid_regs got=%0d/%0h exp=0/0", rf_waddr, rf_wdata); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (rf_we !== 5'd0) begin n_err++; $display("FAIL rstmid_stale[%0d] got=%0h exp=0", i, rf_we); end
    end
  endtask

  task automatic test_forward();
    fwd_raddr = 5'd7;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hA;
    tick();
    n_cmp++; if ({fwd_hit, fwd_data} !== {FWD, FWD ? 32'hA : 32'h0})
      begin n_err++; $display("FAIL fwd_first got=%0b/%0h exp=%0b/%0h", fwd_hit, fwd_data, FWD, FWD ? 32'hA : 32'h0); end
    mem_data = 32'hB;
    tick();
    mem_valid = 1'b0;
    n_cmp++; if ({fwd_hit, fwd_data} !== {FWD, FWD ? 32'hB : 32'h0})
      begin n_err++; $display("FAIL fwd_young got=%0b/%0h exp=%0b/%0h", fwd_hit, fwd_data, FWD, FWD ? 32'hB : 32'h0); end
    fwd_raddr = 5'd0;
    #1;
    n_cmp++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0})
      begin n_err++; $display("FAIL fwd_r0 got=%0b/%0h exp=0/0", fwd_hit, fwd_data); end
    fwd_raddr = 5'd7;
    tick();
    n_cmp++; if ({fwd_hit, fwd_data} !== {FWD, FWD ? 32'hB : 32'h0})
      begin n_err++; $display("FAIL fwd_rfreg got=%0b/%0h exp=%0b/%0h", fwd_hit, fwd_data, FWD, FWD ? 32'hB : 32'h0); end
    tick();
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_drained got=%0b exp=0", fwd_hit); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_priority();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    test_forward();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
